// File: rtl/piso_mux_pkg.sv
// Shared state encoding and default width for piso_mux.
// S_PARITY is only part of the encoding when PISO_MUX_PARITY_EN is defined.
package piso_mux_pkg;

  localparam int DEFAULT_N = 8;

`ifdef PISO_MUX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

endpackage

// File: rtl/piso_mux_mux_n.sv
// Parameterised N:1 combinational bit mux; select codes >= N produce 0.
module mux_n
  import piso_mux_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     data,
  input  logic [SEL_W-1:0] select,
  output logic             out
);

  always_comb begin
    out = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (select == SEL_W'(i)) out = data[i];
    end
  end

endmodule

// File: rtl/piso_mux.sv
// Parallel-in / serial-out: loads an N-bit word, then shifts it out LSB first.
// Define PISO_MUX_PARITY_EN to append an even-parity beat after bit N-1.
module piso_mux
  import piso_mux_pkg::*;
#(
  parameter  int N     = DEFAULT_N,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic [SEL_W-1:0] index,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

  state_t           state_q, state_d;
  logic [N-1:0]     shift_buf_q, shift_buf_d;
  logic [SEL_W-1:0] index_q, index_d;
  logic             load_ready_q, load_ready_d;
  logic             serial_valid_q, serial_valid_d;
  logic             done_q, done_d;
  logic             mux_bit;
  logic             beat;

  mux_n #(.N(N), .SEL_W(SEL_W)) u_mux (
    .data   (shift_buf_q),
    .select (index_q),
    .out    (mux_bit)
  );

  assign beat = serial_valid_q && serial_ready;

  always_comb begin
    state_d        = state_q;
    shift_buf_d    = shift_buf_q;
    index_d        = index_q;
    load_ready_d   = load_ready_q;
    serial_valid_d = serial_valid_q;
    done_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_ready_d   = 1'b1;
        serial_valid_d = 1'b0;
        if (load_valid && load_ready_q) begin
          shift_buf_d    = data_in;
          index_d        = '0;
          state_d        = S_SHIFT;
          load_ready_d   = 1'b0;
          serial_valid_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (beat) begin
          if (index_q != LAST_IDX) begin
            index_d = index_q + SEL_W'(1);
          end else begin
`ifdef PISO_MUX_PARITY_EN
            // index parks on the last bit while the parity beat is presented
            state_d = S_PARITY;
`else
            state_d        = S_IDLE;
            index_d        = '0;
            serial_valid_d = 1'b0;
            load_ready_d   = 1'b1;
            done_d         = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_MUX_PARITY_EN
      S_PARITY: begin
        if (beat) begin
          state_d        = S_IDLE;
          index_d        = '0;
          serial_valid_d = 1'b0;
          load_ready_d   = 1'b1;
          done_d         = 1'b1;
        end
      end
`endif
      default: begin
        state_d        = S_IDLE;
        index_d        = '0;
        serial_valid_d = 1'b0;
        load_ready_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      shift_buf_q    <= '0;
      index_q        <= '0;
      load_ready_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_buf_q    <= shift_buf_d;
      index_q        <= index_d;
      load_ready_q   <= load_ready_d;
      serial_valid_q <= serial_valid_d;
      done_q         <= done_d;
    end
  end

  always_comb begin
    serial_out = 1'b0;
    if (state_q == S_SHIFT) serial_out = mux_bit;
`ifdef PISO_MUX_PARITY_EN
    else if (state_q == S_PARITY) serial_out = ^shift_buf_q;
`endif
  end

  assign load_ready   = load_ready_q;
  assign serial_valid = serial_valid_q;
  assign index        = index_q;
  assign done         = done_q;

endmodule

// File: tb/tb_piso_mux.sv
// Directed bench for piso_mux at N=8, N=5 and N=16 sharing one clock and reset.
module tb_piso_mux;

`ifdef PISO_MUX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic serial_ready = 1'b0;

  logic [7:0]  data8 = '0;
  logic        lv8 = 1'b0, lr8, so8, sv8, done8;
  logic [2:0]  idx8;
  logic [4:0]  data5 = '0;
  logic        lv5 = 1'b0, lr5, so5, sv5, done5;
  logic [2:0]  idx5;
  logic [15:0] data16 = '0;
  logic        lv16 = 1'b0, lr16, so16, sv16, done16;
  logic [3:0]  idx16;

  int vectors = 0;
  int miscompares = 0;

  piso_mux #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .data_in(data8), .load_valid(lv8), .load_ready(lr8),
    .serial_out(so8), .serial_valid(sv8), .serial_ready(serial_ready),
    .index(idx8), .done(done8)
  );

  piso_mux #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .data_in(data5), .load_valid(lv5), .load_ready(lr5),
    .serial_out(so5), .serial_valid(sv5), .serial_ready(serial_ready),
    .index(idx5), .done(done5)
  );

  piso_mux #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .data_in(data16), .load_valid(lv16), .load_ready(lr16),
    .serial_out(so16), .serial_valid(sv16), .serial_ready(serial_ready),
    .index(idx16), .done(done16)
  );

  // Beat i of an n-bit word: data bit i, or the even-parity bit for beat n.
  function automatic logic exp_bit(input logic [63:0] d, input int n, input int i);
    if (i < n) return d[i];
    return ^d;
  endfunction

  function automatic int exp_idx(input int n, input int i);
    return (i < n) ? i : n - 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #11;
    vectors++;
    if ({lr8, sv8, so8, idx8, done8} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state got %b want %b", {lr8, sv8, so8, idx8, done8}, 7'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({lr8, lr5, lr16, sv8, done8} !== 5'b11100) begin
      miscompares++;
      $display("[TB] FAIL reset_release got %b want %b", {lr8, lr5, lr16, sv8, done8}, 5'b11100);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic [5:0] want;
    d = 8'b10101010;
    vectors++;
    if (lr8 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_ready got %b want 1", lr8);
    end
    data8 = d; lv8 = 1'b1; serial_ready = 1'b1;
    @(negedge clk);
    lv8 = 1'b0;
    for (int i = 0; i < 8 + PAR; i++) begin
      want = {1'b1, exp_bit(64'(d), 8, i), 3'(exp_idx(8, i)), 1'b0};
      vectors++;
      if ({sv8, so8, idx8, done8} !== want) begin
        miscompares++;
        $display("[TB] FAIL basic_beat%0d got %b want %b", i, {sv8, so8, idx8, done8}, want);
      end
      @(negedge clk);
    end
    vectors++;
    if ({done8, lr8, sv8, idx8} !== 6'b110000) begin
      miscompares++;
      $display("[TB] FAIL basic_done got %b want %b", {done8, lr8, sv8, idx8}, 6'b110000);
    end
    @(negedge clk);
    vectors++;
    if ({done8, lr8, sv8} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL basic_done_width got %b want %b", {done8, lr8, sv8}, 3'b010);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    logic [3:0] pat;
    logic [4:0] want;
    int i, cyc;
    d = 8'hC3; pat = 4'b1001; i = 0; cyc = 0;
    data8 = d; lv8 = 1'b1; serial_ready = 1'b0;
    @(negedge clk);
    lv8 = 1'b0;
    while (i < 8 + PAR && cyc < 40) begin
      want = {1'b1, exp_bit(64'(d), 8, i), 3'(exp_idx(8, i))};
      vectors++;
      if ({sv8, so8, idx8} !== want) begin
        miscompares++;
        $display("[TB] FAIL bp_cycle%0d got %b want %b", cyc, {sv8, so8, idx8}, want);
      end
      serial_ready = pat[cyc % 4];
      cyc++;
      @(negedge clk);
      if (serial_ready) i++;
    end
    vectors++;
    if (i != 8 + PAR) begin
      miscompares++;
      $display("[TB] FAIL bp_timeout got %0d beats want %0d", i, 8 + PAR);
    end
    vectors++;
    if ({done8, lr8, sv8} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL bp_done got %b want %b", {done8, lr8, sv8}, 3'b110);
    end
    serial_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    localparam int W = 8 + PAR;
    logic [7:0] d;
    logic [5:0] want;
    int pos;
    data8 = 8'h01; lv8 = 1'b1; serial_ready = 1'b1;
    for (int c = 0; c <= 2 * (W + 1); c++) begin
      @(negedge clk);
      if (c == 0) data8 = 8'h80;
      if (c == W + 1) lv8 = 1'b0;
      pos = c % (W + 1);
      d = (c < W + 1) ? 8'h01 : 8'h80;
      if (c == 2 * (W + 1)) begin
        vectors++;
        if ({sv8, done8, lr8} !== 3'b001) begin
          miscompares++;
          $display("[TB] FAIL b2b_idle got %b want %b", {sv8, done8, lr8}, 3'b001);
        end
      end else if (pos < W) begin
        want = {1'b1, exp_bit(64'(d), 8, pos), 3'(exp_idx(8, pos)), 1'b0};
        vectors++;
        if ({sv8, so8, idx8, done8} !== want) begin
          miscompares++;
          $display("[TB] FAIL b2b_cycle%0d got %b want %b", c, {sv8, so8, idx8, done8}, want);
        end
      end else begin
        vectors++;
        if ({sv8, idx8, done8, lr8} !== 6'b000011) begin
          miscompares++;
          $display("[TB] FAIL b2b_done%0d got %b want %b", c, {sv8, idx8, done8, lr8}, 6'b000011);
        end
      end
    end
  endtask

  task automatic test_sweep_n5();
    logic [4:0] vecs [2];
    logic [5:0] want;
    vecs[0] = 5'b10110; vecs[1] = 5'b01001;
    for (int v = 0; v < 2; v++) begin
      data5 = vecs[v]; lv5 = 1'b1; serial_ready = 1'b1;
      @(negedge clk);
      lv5 = 1'b0;
      for (int i = 0; i < 5 + PAR; i++) begin
        want = {1'b1, exp_bit(64'(vecs[v]), 5, i), 3'(exp_idx(5, i)), 1'b0};
        vectors++;
        if ({sv5, so5, idx5, done5} !== want) begin
          miscompares++;
          $display("[TB] FAIL n5_v%0d_beat%0d got %b want %b", v, i, {sv5, so5, idx5, done5}, want);
        end
        @(negedge clk);
      end
      vectors++;
      if ({done5, lr5, sv5, idx5} !== 6'b110000) begin
        miscompares++;
        $display("[TB] FAIL n5_v%0d_done got %b want %b", v, {done5, lr5, sv5, idx5}, 6'b110000);
      end
    end
  endtask

  task automatic test_sweep_n16();
    logic [15:0] vecs [2];
    logic [6:0] want;
    vecs[0] = 16'hBEEF; vecs[1] = 16'h1234;
    for (int v = 0; v < 2; v++) begin
      data16 = vecs[v]; lv16 = 1'b1; serial_ready = 1'b1;
      @(negedge clk);
      lv16 = 1'b0;
      for (int i = 0; i < 16 + PAR; i++) begin
        want = {1'b1, exp_bit(64'(vecs[v]), 16, i), 4'(exp_idx(16, i)), 1'b0};
        vectors++;
        if ({sv16, so16, idx16, done16} !== want) begin
          miscompares++;
          $display("[TB] FAIL n16_v%0d_beat%0d got %b want %b", v, i, {sv16, so16, idx16, done16}, want);
        end
        @(negedge clk);
      end
      vectors++;
      if ({done16, lr16, sv16, idx16} !== 7'b1100000) begin
        miscompares++;
        $display("[TB] FAIL n16_v%0d_done got %b want %b", v, {done16, lr16, sv16, idx16}, 7'b1100000);
      end
    end
  endtask

`ifdef PISO_MUX_PARITY_EN
  task automatic test_parity();
    logic [7:0] vecs [2];
    logic       ninth [2];
    vecs[0] = 8'b10101011; ninth[0] = 1'b1;
    vecs[1] = 8'h00;       ninth[1] = 1'b0;
    for (int v = 0; v < 2; v++) begin
      data8 = vecs[v]; lv8 = 1'b1; serial_ready = 1'b1;
      @(negedge clk);
      lv8 = 1'b0;
      repeat (8) @(negedge clk);
      vectors++;
      if ({sv8, so8, idx8, done8} !== {1'b1, ninth[v], 3'd7, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL parity_v%0d got %b want %b", v, {sv8, so8, idx8, done8}, {1'b1, ninth[v], 3'd7, 1'b0});
      end
      @(negedge clk);
      vectors++;
      if ({done8, lr8, sv8} !== 3'b110) begin
        miscompares++;
        $display("[TB] FAIL parity_v%0d_done got %b want %b", v, {done8, lr8, sv8}, 3'b110);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    vectors++;
    if (lr8 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_ready got %b want 1", lr8);
    end
    data8 = 8'hFF; lv8 = 1'b1; serial_ready = 1'b0;
    @(negedge clk);
    lv8 = 1'b0; serial_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sv8, so8, idx8} !== 5'b11011) begin
      miscompares++;
      $display("[TB] FAIL rstmid_pre got %b want %b", {sv8, so8, idx8}, 5'b11011);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({sv8, so8, idx8, lr8, done8} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_async got %b want %b", {sv8, so8, idx8, lr8, done8}, 7'b0);
    end
    @(negedge clk);
    vectors++;
    if ({sv8, done8, lr8} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL rstmid_held got %b want %b", {sv8, done8, lr8}, 3'b000);
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({lr8, sv8, done8, idx8} !== 6'b100000) begin
        miscompares++;
        $display("[TB] FAIL rstmid_after%0d got %b want %b", c, {lr8, sv8, done8, idx8}, 6'b100000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_sweep_n5();
    test_sweep_n16();
`ifdef PISO_MUX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] simulation exceeded time limit");
  end

endmodule

// File: doc/piso_mux.md
Name: piso_mux

Overview:
- Parameterised parallel-in / serial-out block. An N:1 select mux is driven by an internal bit counter instead of an external `select` input.
- Captures an N-bit word through a valid/ready load handshake, then emits one bit per accepted serial beat, bit index 0 first.
- Sits between parallel datapaths and single-wire serial consumers. It is the sequential successor of the combinational 8:1 mux.

Parameters:
- N, 8, data word width in bits; legal range 2 to 64.
- SEL_W, $clog2(N), width of the internal index counter; derived, never overridden.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-low reset
- data_in  input  N  parallel word to serialise
- load_valid  input  1  data_in is valid
- load_ready  output  1  block can accept a word
- serial_out  output  1  current serial bit
- serial_valid  output  1  serial_out is valid
- serial_ready  input  1  consumer accepts serial_out this cycle
- index  output  SEL_W  bit index currently presented on serial_out
- done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset is asynchronous, active-low: rst low immediately forces the following values:
  - state=IDLE, shift_buf=0, index=0
  - load_ready=0 while rst is low, then 1 from the first clk edge after release
  - serial_valid=0, serial_out=0, done=0
- States: IDLE, SHIFT, PARITY. PARITY exists only with the optional feature.
- IDLE:
  - load_ready=1, serial_valid=0.
  - On load_valid&&load_ready: shift_buf<=data_in, index<=0, next state SHIFT.
- SHIFT:
  - load_ready=0, serial_valid=1.
  - serial_out=shift_buf[index], combinational through the mux from registered index and buffer.
  - On serial_valid&&serial_ready with index<N-1: index<=index+1.
  - On the handshake with index==N-1: next state IDLE (or PARITY), index<=0.
  - Without serial_ready, serial_out and index hold stable (AXI-style: valid never drops before the handshake).
- Latency:
  - First serial bit is valid the cycle after load acceptance.
  - One bit per cycle while serial_ready=1: N beats for N bits.
  - done pulses in the cycle after the final accepted beat. It is registered, high for exactly 1 cycle, and coincident with load_ready returning to 1.
- There is no load acceptance while busy. A minimum 1-cycle IDLE bubble separates words, so sustained throughput is N bits per N+1 cycles.
- data_in changes during SHIFT are ignored; the buffer is captured only at load.
- rst asserted mid-word aborts the transfer: partial output is discarded, done is not pulsed, state returns to IDLE.
- Index wrap: index never exceeds N-1. For non-power-of-2 N, the unused counter codes are unreachable; the mux outputs 0 if forced there.

Optional Feature:
- Macro: PISO_MUX_PARITY_EN.
- Defined:
  - After bit N-1 is accepted, the block enters PARITY.
  - serial_out = XOR of shift_buf (even parity), serial_valid=1, index holds N-1.
  - The parity beat uses the same handshake; done pulses after it is accepted. Beats per word = N+1.
- Undefined: the PARITY state, its logic and its encoding are absent; behaviour is as above.

Decomposition:
- Package piso_mux_pkg holds:
  - typedef enum logic [1:0] state_t {S_IDLE, S_SHIFT, S_PARITY}
  - localparam for the default width
- Sub-module mux_n:
  - Parameterised N:1 combinational mux with ports data[N-1:0], select[SEL_W-1:0], out.
  - Out-of-range select yields 0.
  - Instantiated once for serial_out.

Test Plan:
- Reset mid-word: load 8'hFF, release serial_ready for 3 beats, assert rst low asynchronously between edges → serial_valid=0 and index=0 immediately; no done pulse; load_ready=1 after rst release.
- Basic N=8: data_in=8'b10101010, serial_ready held 1 → serial_out sequence 0,1,0,1,0,1,0,1 with index 0..7 on consecutive cycles; done high exactly 1 cycle, 9 cycles after load.
- Backpressure: data_in=8'hC3, serial_ready toggled 1,0,0,1,... → serial_out and index stable through stall cycles; bit order still 1,1,0,0,0,0,1,1.
- Back-to-back: load_valid held high with 8'h01 then 8'h80 → second word accepted only in the IDLE cycle after done; no bit dropped or duplicated.
- Parameter sweep, N=5 and N=16: random data → serial stream LSB-first matches data_in; index never exceeds N-1.
- With PISO_MUX_PARITY_EN defined: data_in=8'b10101011 (5 ones) → ninth beat serial_out=1; for 8'h00 the ninth beat is 0; done follows the ninth beat.
